serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial multi-bit adder built around one fulladder instance plus a carry flip-flop.
//   Loads two WIDTH-bit operands, adds one bit per clock LSB-first and reports
//   sum/carryout/overflow with a start/busy/done handshake.
//   Feeds the fulladder stage and consumes its outputs.
//   Serves as the low-area alternative to the ripple-carry add16 in the ALU datapath.
// PARAMETERS
//   WIDTH  16  operand/sum width in bits; legal range 1..64
// PORTS
//   clk       in   1      single system clock, rising edge
//   reset     in   1      synchronous, active-high; sampled on rising clk
//   start     in   1      request; sampled only in IDLE
//   a         in   WIDTH  operand A; captured on accepted start
//   b         in   WIDTH  operand B; captured on accepted start
//   carryin   in   1      initial carry; captured on accepted start
//   busy      out  1      high while in SHIFT
//   done      out  1      one-cycle pulse: results valid
//   sum       out  WIDTH  a+b+carryin mod 2^WIDTH; held until next accepted start
//   carryout  out  1      carry out of bit WIDTH-1
//   overflow  out  1      signed overflow = carry into MSB XOR carryout
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, sum=0, carryout=0, overflow=0.
//     Internal shift registers, carry flip-flop and bit counter are cleared.
//   States: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE:
//     - start=1: a_sr<=a, b_sr<=b, cy<=carryin, cnt<=0; next state SHIFT.
//     - start=0: hold; sum, carryout and overflow keep their last values.
//   SHIFT (exactly WIDTH cycles):
//     - fulladder inputs: a_sr[0], b_sr[0], cy.
//     - Each cycle: a_sr, b_sr shift right; fa.out shifts into sum_sr at MSB;
//       cy<=fa.carryout; cnt<=cnt+1.
//     - On the bit with cnt==WIDTH-1: record cin_msb=cy (pre-update value).
//     - When cnt==WIDTH-1, next state is DONE.
//     - busy=1 throughout.
//   DONE (1 cycle):
//     - done=1, busy=0.
//     - sum=sum_sr, carryout=cy, overflow=cin_msb^cy.
//     - Outputs are registered and remain stable after DONE.
//     - Next state IDLE unconditionally.
//   Latency: start accepted at edge N -> done high during cycle after edge N+WIDTH+1.
//     Throughput is one add per WIDTH+2 cycles.
//   Boundary conditions:
//     - start while busy or in DONE: ignored, no effect on the operation in flight.
//     - Operands changing after capture: ignored.
//     - sum does not change during SHIFT; it updates only at DONE.
//     - reset asserted mid-SHIFT: abort; next cycle is IDLE with all outputs 0.
//       No done pulse is produced.
//     - reset and start asserted together: reset wins.
//     - WIDTH=1: one SHIFT cycle; overflow = carryin ^ carryout.
//     - Wrap-around: all-ones + 1 gives sum=0, carryout=1.
//   Bit counter width: $clog2(WIDTH+1); must not wrap before reaching WIDTH-1.
// TESTING
//   1. reset high 2 cycles, then low -> busy=0, done=0, sum=0, carryout=0, overflow=0.
//   2. WIDTH=16, a=16'h1234, b=16'h4321, cin=0, start ->
//        done 18 cycles later; sum=16'h5555, carryout=0, overflow=0.
//   3. WIDTH=16, a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, carryout=1, overflow=0.
//   4. WIDTH=16, a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, carryout=0, overflow=1.
//   5. WIDTH=4, exhaustive: all 512 (a,b,cin) combinations vs a+b+cin reference ->
//        zero mismatches.
//      Also pulse start mid-op with other operands -> result unchanged.
//   6. Mid-SHIFT reset (cycle 5 of 16) -> no done pulse, outputs 0.
//      A following start with a=3, b=4 -> sum=7.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flip-flop, LSB first.
// A captured add takes WIDTH shift cycles and one DONE cycle. Results are
// registered and held until the next accepted start.

module fulladder (
   input  logic a,
   input  logic b,
   input  logic carryin,
   output logic out,
   output logic carryout
);

   // Single-bit sum and carry
   always_comb begin
      out      = a ^ b ^ carryin;
      carryout = (a & b) | (carryin & (a ^ b));
   end

endmodule

module serial_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carryin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carryout,
   output logic             overflow
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_sr_q;
   logic [WIDTH-1:0] b_sr_q;
   logic [WIDTH-1:0] sum_sr_q;
   logic             cy_q;
   logic             cin_msb_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             carryout_q;
   logic             overflow_q;

   logic             fa_out_d;
   logic             fa_cy_d;
   logic [WIDTH-1:0] msb_ins_d;

   fulladder fa (
      .a        (a_sr_q[0]),
      .b        (b_sr_q[0]),
      .carryin  (cy_q),
      .out      (fa_out_d),
      .carryout (fa_cy_d)
   );

   // Full-adder sum bit placed at the MSB position; written this way so
   // WIDTH=1 needs no zero-width concatenation.
   always_comb begin
      msb_ins_d            = '0;
      msb_ins_d[WIDTH-1]   = fa_out_d;
   end

   // Control FSM, datapath shift registers and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         a_sr_q     <= '0;
         b_sr_q     <= '0;
         sum_sr_q   <= '0;
         cy_q       <= 1'b0;
         cin_msb_q  <= 1'b0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sum_q      <= '0;
         carryout_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_sr_q   <= a;
                  b_sr_q   <= b;
                  sum_sr_q <= '0;
                  cy_q     <= carryin;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               a_sr_q   <= a_sr_q >> 1;
               b_sr_q   <= b_sr_q >> 1;
               sum_sr_q <= (sum_sr_q >> 1) | msb_ins_d;
               cy_q     <= fa_cy_d;
               cnt_q    <= cnt_q + ONE;
               if (cnt_q == LAST) begin
                  cin_msb_q <= cy_q;
                  busy_q    <= 1'b0;
                  state_q   <= S_DONE;
               end
            end
            S_DONE: begin
               done_q     <= 1'b1;
               sum_q      <= sum_sr_q;
               carryout_q <= cy_q;
               overflow_q <= cin_msb_q ^ cy_q;
               state_q    <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign carryout = carryout_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=16, 4 and 1.

module tb_serial_adder;

   logic clk = 1'b0;
   logic reset;

   logic        st16, ci16, busy16, done16, co16, ov16;
   logic [15:0] a16, b16, sum16;
   logic        st4, ci4, busy4, done4, co4, ov4;
   logic [3:0]  a4, b4, sum4;
   logic        st1, ci1, busy1, done1, co1, ov1;
   logic [0:0]  a1, b1, sum1;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned cur_w = 16;

   logic [63:0] sum_s;
   logic        done_s, busy_s, co_s, ov_s;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .start(st16), .a(a16), .b(b16), .carryin(ci16),
      .busy(busy16), .done(done16), .sum(sum16), .carryout(co16), .overflow(ov16)
   );

   serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .start(st4), .a(a4), .b(b4), .carryin(ci4),
      .busy(busy4), .done(done4), .sum(sum4), .carryout(co4), .overflow(ov4)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .reset(reset), .start(st1), .a(a1), .b(b1), .carryin(ci1),
      .busy(busy1), .done(done1), .sum(sum1), .carryout(co1), .overflow(ov1)
   );

   // Output view of whichever instance is under test
   always_comb begin
      sum_s  = '0;
      done_s = 1'b0;
      busy_s = 1'b0;
      co_s   = 1'b0;
      ov_s   = 1'b0;
      case (cur_w)
         16: begin sum_s[15:0] = sum16; done_s = done16; busy_s = busy16; co_s = co16; ov_s = ov16; end
         4:  begin sum_s[3:0]  = sum4;  done_s = done4;  busy_s = busy4;  co_s = co4;  ov_s = ov4;  end
         default: begin sum_s[0] = sum1[0]; done_s = done1; busy_s = busy1; co_s = co1; ov_s = ov1; end
      endcase
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int unsigned w, input logic [63:0] av, input logic [63:0] bv,
                        input logic ci, input logic st);
      case (w)
         16: begin a16 = av[15:0]; b16 = bv[15:0]; ci16 = ci; st16 = st; end
         4:  begin a4  = av[3:0];  b4  = bv[3:0];  ci4  = ci; st4  = st; end
         default: begin a1 = av[0:0]; b1 = bv[0:0]; ci1 = ci; st1 = st; end
      endcase
   endtask

   // One add: start accepted at an edge, count edges until done is seen.
   // With inject set, start stays high with different operands while in flight.
   task automatic run_add(input int unsigned w, input logic [63:0] av, input logic [63:0] bv,
                          input logic ci, input bit inject,
                          output logic [63:0] s, output logic co, output logic ov,
                          output int unsigned lat);
      logic [63:0] held;
      cur_w = w;
      @(negedge clk);
      drive(w, av, bv, ci, 1'b1);
      @(posedge clk); #1;
      held = sum_s;
      if (w == 16) check("busy_after_start", {63'd0, busy_s}, 64'd1);
      drive(w, ~av, ~bv, ~ci, inject);
      lat = 0;
      for (int k = 1; k <= 80; k++) begin
         @(posedge clk); #1;
         if (k == 2) drive(w, ~av, ~bv, ~ci, 1'b0);
         if (done_s) begin
            lat = k;
            break;
         end
         if (w == 16) check("sum_hold_shift", sum_s, held);
      end
      drive(w, ~av, ~bv, ~ci, 1'b0);
      s  = sum_s;
      co = co_s;
      ov = ov_s;
      @(posedge clk); #1;
      check("done_one_cycle", {63'd0, done_s}, 64'd0);
      check("sum_held_after", sum_s, s);
   endtask

   logic [63:0]  s;
   logic         co, ov;
   int unsigned  lat;
   logic [4:0]   ref4;
   logic [5:0]   w1_tab [8];
   int unsigned  done_seen;

   initial begin
      reset = 1'b1;
      drive(16, 64'd0, 64'd0, 1'b0, 1'b0);
      drive(4,  64'd0, 64'd0, 1'b0, 1'b0);
      drive(1,  64'd0, 64'd0, 1'b0, 1'b0);

      // Reset for two cycles
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      cur_w = 16;
      #0;
      check("rst_busy", {63'd0, busy16}, 64'd0);
      check("rst_done", {63'd0, done16}, 64'd0);
      check("rst_sum",  {48'd0, sum16},  64'd0);
      check("rst_co",   {63'd0, co16},   64'd0);
      check("rst_ov",   {63'd0, ov16},   64'd0);

      // WIDTH=16 directed vectors
      run_add(16, 64'h1234, 64'h4321, 1'b0, 1'b0, s, co, ov, lat);
      check("v1_lat", 64'(lat), 64'd17);
      check("v1_sum", s, 64'h5555);
      check("v1_co",  {63'd0, co}, 64'd0);
      check("v1_ov",  {63'd0, ov}, 64'd0);

      run_add(16, 64'hFFFF, 64'h0000, 1'b1, 1'b0, s, co, ov, lat);
      check("v2_lat", 64'(lat), 64'd17);
      check("v2_sum", s, 64'h0000);
      check("v2_co",  {63'd0, co}, 64'd1);
      check("v2_ov",  {63'd0, ov}, 64'd0);

      run_add(16, 64'h7FFF, 64'h0001, 1'b0, 1'b0, s, co, ov, lat);
      check("v3_lat", 64'(lat), 64'd17);
      check("v3_sum", s, 64'h8000);
      check("v3_co",  {63'd0, co}, 64'd0);
      check("v3_ov",  {63'd0, ov}, 64'd1);

      run_add(16, 64'h8000, 64'h8000, 1'b0, 1'b1, s, co, ov, lat);
      check("v4_lat", 64'(lat), 64'd17);
      check("v4_sum", s, 64'h0000);
      check("v4_co",  {63'd0, co}, 64'd1);
      check("v4_ov",  {63'd0, ov}, 64'd1);

      // Mid-SHIFT reset: abort, outputs cleared, no done pulse
      cur_w = 16;
      @(negedge clk);
      drive(16, 64'hABCD, 64'h1111, 1'b0, 1'b1);
      @(posedge clk); #1;
      drive(16, 64'hABCD, 64'h1111, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_rst_busy", {63'd0, busy16}, 64'd0);
      check("mid_rst_sum",  {48'd0, sum16},  64'd0);
      check("mid_rst_co",   {63'd0, co16},   64'd0);
      check("mid_rst_ov",   {63'd0, ov16},   64'd0);
      done_seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (done16) done_seen++;
      end
      check("mid_rst_no_done", 64'(done_seen), 64'd0);

      run_add(16, 64'd3, 64'd4, 1'b0, 1'b0, s, co, ov, lat);
      check("post_rst_lat", 64'(lat), 64'd17);
      check("post_rst_sum", s, 64'd7);

      // Reset and start together: reset wins
      @(negedge clk);
      reset = 1'b1;
      drive(16, 64'h0001, 64'h0001, 1'b0, 1'b1);
      @(posedge clk); #1;
      check("rst_start_busy", {63'd0, busy16}, 64'd0);
      check("rst_start_sum",  {48'd0, sum16},  64'd0);
      reset = 1'b0;
      drive(16, 64'h0001, 64'h0001, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("rst_start_idle", {63'd0, busy16}, 64'd0);

      // WIDTH=4 exhaustive against a+b+cin
      for (int unsigned i = 0; i < 512; i++) begin
         logic [3:0] av, bv;
         logic       cv;
         av = i[3:0];
         bv = i[7:4];
         cv = i[8];
         ref4 = {1'b0, av} + {1'b0, bv} + {4'd0, cv};
         run_add(4, {60'd0, av}, {60'd0, bv}, cv, (i % 37) == 0, s, co, ov, lat);
         check("w4_lat", 64'(lat), 64'd5);
         check("w4_sum", s, {60'd0, ref4[3:0]});
         check("w4_co",  {63'd0, co}, {63'd0, ref4[4]});
         check("w4_ov",  {63'd0, ov},
               {63'd0, (av[3] == bv[3]) && (ref4[3] != av[3])});
      end

      // WIDTH=1: {a, b, cin, sum, carryout, overflow}
      w1_tab[0] = 6'b000_000;
      w1_tab[1] = 6'b001_101;
      w1_tab[2] = 6'b010_100;
      w1_tab[3] = 6'b011_010;
      w1_tab[4] = 6'b100_100;
      w1_tab[5] = 6'b101_010;
      w1_tab[6] = 6'b110_011;
      w1_tab[7] = 6'b111_110;
      for (int i = 0; i < 8; i++) begin
         run_add(1, {63'd0, w1_tab[i][5]}, {63'd0, w1_tab[i][4]}, w1_tab[i][3], 1'b0,
                 s, co, ov, lat);
         check("w1_lat", 64'(lat), 64'd2);
         check("w1_sum", s, {63'd0, w1_tab[i][2]});
         check("w1_co",  {63'd0, co}, {63'd0, w1_tab[i][1]});
         check("w1_ov",  {63'd0, ov}, {63'd0, w1_tab[i][0]});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
